// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_ctrl
//  Function : 4-digit multiplexed 7-segment scan driver for a stopwatch.
//             It shows sec:msec or hour:min from a per-frame snapshot.
//  Revision : 1.0  initial release
// ============================================================================
module fnd_scan_ctrl #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int                 c_CNT_W    = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_TICK_MAX = c_CNT_W'(SCAN_DIV - 1);

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic [1:0]         r_digit;
    logic               r_snap_mode;
    logic [6:0]         r_snap_msec;
    logic [5:0]         r_snap_sec;
    logic [5:0]         r_snap_min;
    logic [4:0]         r_snap_hour;

    logic               w_tick;
    logic               w_frame_end;
    logic [6:0]         w_hi_val;
    logic [6:0]         w_lo_val;
    logic [3:0]         w_digit_val;
    logic               w_dp_n;

    function automatic logic [3:0] ones_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'((v / 7'd10) % 7'd10);
    endfunction

    // Segment pattern g..a, active low
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tick      = (r_tick_cnt == c_TICK_MAX);
    assign w_frame_end = w_tick && (r_digit == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_digit    <= 2'd0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CNT_W'(1);
            if (w_tick) begin
                r_digit <= r_digit + 2'd1;
            end
        end
    end

    // Inputs are captured once per frame so a frame never mixes old and new values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_mode <= 1'b0;
            r_snap_msec <= '0;
            r_snap_sec  <= '0;
            r_snap_min  <= '0;
            r_snap_hour <= '0;
        end else if (w_frame_end) begin
            r_snap_mode <= disp_mode;
            r_snap_msec <= msec;
            r_snap_sec  <= sec;
            r_snap_min  <= min;
            r_snap_hour <= hour;
        end
    end

    always_comb begin
        w_hi_val    = r_snap_mode ? {2'b00, r_snap_hour} : {1'b0, r_snap_sec};
        w_lo_val    = r_snap_mode ? {1'b0, r_snap_min}   : r_snap_msec;
        w_digit_val = 4'd0;
        case (r_digit)
            2'd0:    w_digit_val = ones_of(w_lo_val);
            2'd1:    w_digit_val = tens_of(w_lo_val);
            2'd2:    w_digit_val = ones_of(w_hi_val);
            default: w_digit_val = tens_of(w_hi_val);
        endcase
        w_dp_n = !((r_digit == 2'd2) && (r_snap_msec < 7'd50));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            fnd_com  <= ~(4'b0001 << r_digit);
            fnd_data <= {w_dp_n, seg_code(w_digit_val)};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_ctrl
//  Function : Scoreboard bench for fnd_scan_ctrl with SCAN_DIV = 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fnd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       disp_mode = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    typedef struct {
        logic [3:0] com;
        logic [7:0] data;
        int         dur;
    } slot_t;

    slot_t       exp_q[$];
    slot_t       cur;
    bit          have_cur = 1'b0;
    logic [11:0] prev = 'x;
    int          run_len = 0;
    int          slot_idx = 0;
    int          checks = 0;
    int          errors = 0;

    fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_mode (disp_mode),
        .msec      (msec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input logic [3:0] com, input logic [7:0] data, input int dur);
        slot_t s;
        s.com  = com;
        s.data = data;
        s.dur  = dur;
        exp_q.push_back(s);
    endtask

    task automatic expect_frame(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        expect_slot(4'b1110, d0, 4);
        expect_slot(4'b1101, d1, 4);
        expect_slot(4'b1011, d2, 4);
        expect_slot(4'b0111, d3, 4);
    endtask

    // Each change of the display outputs is one presented slot
    always @(negedge clk) begin
        if ({fnd_com, fnd_data} !== prev) begin
            if (have_cur && cur.dur != 0) begin
                checks++;
                if (run_len != cur.dur) begin
                    errors++;
                    $display("FAIL hold_len slot=%0d got %0d cycles expected %0d",
                             slot_idx - 1, run_len, cur.dur);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                have_cur = 1'b0;
                $display("FAIL unexpected_slot slot=%0d got com=%b data=%h expected none",
                         slot_idx, fnd_com, fnd_data);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                if (fnd_com !== cur.com || fnd_data !== cur.data) begin
                    errors++;
                    $display("FAIL slot_value slot=%0d got com=%b data=%h expected com=%b data=%h",
                             slot_idx, fnd_com, fnd_data, cur.com, cur.data);
                end
            end
            prev = {fnd_com, fnd_data};
            run_len = 1;
            slot_idx++;
        end else begin
            run_len++;
        end
    end

    initial begin
        // Reset for 3 cycles; inputs already set must not show in the first frame
        sec = 6'd37; msec = 7'd42; disp_mode = 1'b0;
        expect_slot(4'b1111, 8'hFF, 3);
        expect_frame(8'hC0, 8'hC0, 8'h40, 8'hC0);
        expect_frame(8'hA4, 8'h99, 8'h78, 8'hB0);
        step(3);
        rst = 1'b0;

        // sec changes while d1 of the 37.42 frame is lit
        step(22);
        sec = 6'd38;
        expect_frame(8'hA4, 8'h99, 8'h00, 8'hB0);

        step(14);
        disp_mode = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd75;
        expect_frame(8'h92, 8'hC0, 8'hB0, 8'hA4);

        step(16);
        disp_mode = 1'b0; msec = 7'd127; sec = 6'd38;
        expect_frame(8'hF8, 8'hA4, 8'h80, 8'hB0);

        step(16);
        sec = 6'd59; msec = 7'd10;
        expect_slot(4'b1110, 8'hC0, 4);
        expect_slot(4'b1101, 8'hF9, 4);
        expect_slot(4'b1011, 8'h10, 1);

        // Reset lands on the first cycle of d2
        step(21);
        rst = 1'b1;
        expect_slot(4'b1111, 8'hFF, 2);
        expect_frame(8'hC0, 8'hC0, 8'h40, 8'hC0);
        expect_frame(8'hC0, 8'hF9, 8'h10, 8'h92);
        step(2);
        rst = 1'b0;

        step(32);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_slots got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
